// File: rtl/apb_flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// apb_flash_arb_pkg : APB widths, arbiter state encodings and timeout default
// Revision: 1.0
// ============================================================================
package apb_flash_arb_pkg;

   localparam int P_ADDR_W = 32;
   localparam int P_DATA_W = 32;
   localparam int P_STRB_W = P_DATA_W / 8;

   localparam int ARB_TO_W = 13;

   localparam logic [2:0] ARB_IDLE   = 3'd0;
   localparam logic [2:0] ARB_SETUP  = 3'd1;
   localparam logic [2:0] ARB_ACCESS = 3'd2;
   localparam logic [2:0] ARB_RESP   = 3'd3;
   localparam logic [2:0] ARB_DRAIN  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ARB_IDLE,
      ST_SETUP  = ARB_SETUP,
      ST_ACCESS = ARB_ACCESS,
      ST_RESP   = ARB_RESP,
      ST_DRAIN  = ARB_DRAIN
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_flash_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// apb_rr_pick : two-requester round-robin picker, purely combinational
// Revision: 1.0
// ============================================================================
module apb_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_vld,
   output logic       gnt
);

   // On a tie the port that was not served last wins.
   assign gnt_vld = |req;
   assign gnt     = (&req) ? ~last : req[1];

endmodule
`default_nettype wire

// File: rtl/apb_flash_arb.sv
`default_nettype none
// ============================================================================
// apb_flash_arb : two-port APB arbiter in front of the SPI flash read bridge,
//                 with an access-phase watchdog and downstream drain
// Revision: 1.0
// ============================================================================
module apb_flash_arb
   import apb_flash_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = ARB_TO_W
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic [P_ADDR_W-1:0] s0_paddr,
   input  logic                s0_psel,
   input  logic                s0_penable,
   input  logic                s0_pwrite,
   input  logic [P_DATA_W-1:0] s0_pwdata,
   input  logic [P_STRB_W-1:0] s0_pwstrb,
   output logic                s0_pready,
   output logic [P_DATA_W-1:0] s0_prdata,
   output logic                s0_pslverr,
   input  logic [P_ADDR_W-1:0] s1_paddr,
   input  logic                s1_psel,
   input  logic                s1_penable,
   input  logic                s1_pwrite,
   input  logic [P_DATA_W-1:0] s1_pwdata,
   input  logic [P_STRB_W-1:0] s1_pwstrb,
   output logic                s1_pready,
   output logic [P_DATA_W-1:0] s1_prdata,
   output logic                s1_pslverr,
   output logic [P_ADDR_W-1:0] m_paddr,
   output logic                m_psel,
   output logic                m_penable,
   output logic                m_pwrite,
   output logic [P_DATA_W-1:0] m_pwdata,
   output logic [P_STRB_W-1:0] m_pwstrb,
   input  logic                m_pready,
   input  logic [P_DATA_W-1:0] m_prdata,
   input  logic                m_pslverr,
   output logic                to_pulse
);

   if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
   if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_chk_to_w
      $error("TO_W too narrow for TIMEOUT_CYCLES");
   end

   arb_state_e          r_state;
   logic                r_gnt;
   logic                r_last_gnt;
   logic [TO_W-1:0]     r_cnt;
   logic                r_drain;
   logic [P_DATA_W-1:0] r_rdata;
   logic                r_rerr;
   logic                w_gnt_vld;
   logic                w_gnt;
   logic                w_resp;

   apb_rr_pick u_pick (
      .req     ({s1_psel, s0_psel}),
      .last    (r_last_gnt),
      .gnt_vld (w_gnt_vld),
      .gnt     (w_gnt)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state    <= ST_IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_cnt      <= '0;
         r_drain    <= 1'b0;
         r_rdata    <= '0;
         r_rerr     <= 1'b0;
         m_paddr    <= '0;
         m_psel     <= 1'b0;
         m_penable  <= 1'b0;
         m_pwrite   <= 1'b0;
         m_pwdata   <= '0;
         m_pwstrb   <= '0;
         to_pulse   <= 1'b0;
      end else begin
         to_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  m_paddr    <= w_gnt ? s1_paddr  : s0_paddr;
                  m_pwrite   <= w_gnt ? s1_pwrite : s0_pwrite;
                  m_pwdata   <= w_gnt ? s1_pwdata : s0_pwdata;
                  m_pwstrb   <= w_gnt ? s1_pwstrb : s0_pwstrb;
                  m_psel     <= 1'b1;
                  r_gnt      <= w_gnt;
                  r_last_gnt <= w_gnt;
                  r_drain    <= 1'b0;
                  r_state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               m_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A ready on the expiry cycle is still a normal completion.
               if (m_pready) begin
                  r_rdata   <= m_prdata;
                  r_rerr    <= m_pslverr;
                  m_psel    <= 1'b0;
                  m_penable <= 1'b0;
                  r_state   <= ST_RESP;
               end else if (r_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_rdata  <= '0;
                  r_rerr   <= 1'b1;
                  to_pulse <= 1'b1;
                  r_drain  <= 1'b1;
                  r_state  <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            ST_RESP: begin
               // Downstream may finish during the RESP cycle itself; then skip DRAIN.
               if (r_drain && !m_pready) begin
                  r_state <= ST_DRAIN;
               end else begin
                  m_psel    <= 1'b0;
                  m_penable <= 1'b0;
                  r_drain   <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (m_pready) begin
                  m_psel    <= 1'b0;
                  m_penable <= 1'b0;
                  r_drain   <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_resp = (r_state == ST_RESP);

   assign s0_pready  = w_resp & ~r_gnt & s0_psel & s0_penable;
   assign s0_prdata  = s0_pready ? r_rdata : '0;
   assign s0_pslverr = s0_pready & r_rerr;

   assign s1_pready  = w_resp & r_gnt & s1_psel & s1_penable;
   assign s1_prdata  = s1_pready ? r_rdata : '0;
   assign s1_pslverr = s1_pready & r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_apb_flash_arb.sv
`default_nettype none
// ============================================================================
// tb_apb_flash_arb : directed bench with a transfer-level reference model
// Revision: 1.0
// ============================================================================
module tb_apb_flash_arb;
   import apb_flash_arb_pkg::*;

   localparam int TO = 8;

   logic                pclk = 1'b0;
   logic                presetn = 1'b0;
   logic [P_ADDR_W-1:0] paddr  [2];
   logic [P_DATA_W-1:0] pwdata [2];
   logic [P_STRB_W-1:0] pwstrb [2];
   logic [1:0]          psel, penable, pwrite;
   logic                s0_pready, s1_pready, s0_pslverr, s1_pslverr;
   logic [P_DATA_W-1:0] s0_prdata, s1_prdata;
   logic [P_ADDR_W-1:0] m_paddr;
   logic                m_psel, m_penable, m_pwrite;
   logic [P_DATA_W-1:0] m_pwdata;
   logic [P_STRB_W-1:0] m_pwstrb;
   logic                m_pready, m_pslverr;
   logic [P_DATA_W-1:0] m_prdata;
   logic                to_pulse;

   always #5 pclk = ~pclk;

   apb_flash_arb #(.TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
      .pclk(pclk), .presetn(presetn),
      .s0_paddr(paddr[0]), .s0_psel(psel[0]), .s0_penable(penable[0]), .s0_pwrite(pwrite[0]),
      .s0_pwdata(pwdata[0]), .s0_pwstrb(pwstrb[0]),
      .s0_pready(s0_pready), .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr),
      .s1_paddr(paddr[1]), .s1_psel(psel[1]), .s1_penable(penable[1]), .s1_pwrite(pwrite[1]),
      .s1_pwdata(pwdata[1]), .s1_pwstrb(pwstrb[1]),
      .s1_pready(s1_pready), .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr),
      .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
      .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
      .to_pulse(to_pulse)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Per-port downstream behaviour: wait cycles, read data, error flag.
   int          dn_wait [2];
   logic [31:0] dn_data [2];
   logic        dn_err  [2];

   // Reference model state: one forwarded transfer at a time, indexed from its first m_psel cycle.
   bit          act = 1'b0;
   bit          last_m = 1'b1;
   int          idx, own, cur_w, exp_rdy;
   logic [1:0]  psel_prev = 2'b00;
   logic [31:0] snap_addr, snap_wdata;
   logic [3:0]  snap_strb;
   logic        snap_write;
   int          pulse_cnt = 0;
   logic        own_rdy, oth_rdy;
   logic [31:0] own_data;
   logic        own_err;

   initial begin : compare
      forever begin
         @(negedge pclk);
         if (!presetn) begin
            act    = 1'b0;
            last_m = 1'b1;
            check("rst_m_psel", m_psel, 0);
            check("rst_s0_pready", s0_pready, 0);
            check("rst_s1_pready", s1_pready, 0);
            check("rst_to_pulse", to_pulse, 0);
         end else begin
            if (!act && m_psel) begin
               act = 1'b1;
               idx = 0;
               own = (psel_prev == 2'b11) ? (last_m ? 0 : 1) : (psel_prev[1] ? 1 : 0);
               last_m = (own == 1);
               cur_w  = dn_wait[own];
               snap_addr  = paddr[own];
               snap_wdata = pwdata[own];
               snap_strb  = pwstrb[own];
               snap_write = pwrite[own];
            end
            if (act) begin
               exp_rdy  = (cur_w < TO) ? 2 + cur_w : TO + 1;
               own_rdy  = (own == 1) ? s1_pready : s0_pready;
               oth_rdy  = (own == 1) ? s0_pready : s1_pready;
               own_data = (own == 1) ? s1_prdata : s0_prdata;
               own_err  = (own == 1) ? s1_pslverr : s0_pslverr;
               check("m_psel", m_psel, idx <= 1 + cur_w);
               if (m_psel) begin
                  check("m_penable", m_penable, idx >= 1);
                  check("m_paddr", m_paddr, snap_addr);
                  check("m_pwdata", m_pwdata, snap_wdata);
                  check("m_pwstrb", m_pwstrb, snap_strb);
                  check("m_pwrite", m_pwrite, snap_write);
               end
               check("to_pulse", to_pulse, (cur_w >= TO) && (idx == TO + 1));
               check("pready_owner", own_rdy, idx == exp_rdy);
               check("pready_other", oth_rdy, 0);
               if (idx == exp_rdy) begin
                  check("prdata", own_data, (cur_w < TO) ? dn_data[own] : 32'h0);
                  check("pslverr", own_err, (cur_w < TO) ? dn_err[own] : 1'b1);
               end
               idx++;
               if (idx > 2 + cur_w) act = 1'b0;
            end else begin
               check("idle_s0_pready", s0_pready, 0);
               check("idle_s1_pready", s1_pready, 0);
               check("idle_to_pulse", to_pulse, 0);
               check("idle_m_penable", m_penable, 0);
            end
            if (!s0_pready) check("s0_resp_zero", {s0_pslverr, s0_prdata[30:0]} | {31'h0, s0_prdata[31]}, 0);
            if (!s1_pready) check("s1_resp_zero", {s1_pslverr, s1_prdata[30:0]} | {31'h0, s1_prdata[31]}, 0);
         end
         if (to_pulse) pulse_cnt++;
         psel_prev = psel;
      end
   end

   // Downstream completer: ready after dn_wait access cycles of the model's current owner.
   int acc = 0;
   bit in_acc = 1'b0;
   initial begin : completer
      m_pready  = 1'b0;
      m_prdata  = '0;
      m_pslverr = 1'b0;
      forever begin
         @(posedge pclk);
         #1;
         if (m_psel && m_penable) begin
            if (in_acc) acc++;
            else begin
               acc    = 0;
               in_acc = 1'b1;
            end
         end else begin
            in_acc = 1'b0;
         end
         m_pready  = m_psel && m_penable && (acc == cur_w);
         m_prdata  = m_pready ? dn_data[own] : 32'hFFFF_FFFF;
         m_pslverr = m_pready && dn_err[own];
      end
   end

   task automatic xfer(input int p, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er, output int lat);
      int cnt = 0;
      paddr[p] = a; pwrite[p] = wr; pwdata[p] = wd; pwstrb[p] = st;
      psel[p] = 1'b1; penable[p] = 1'b0;
      rd = '0; er = 1'b0; lat = 0;
      forever begin
         @(posedge pclk);
         cnt++;
         #1 penable[p] = 1'b1;
         @(negedge pclk);
         if ((p == 1) ? s1_pready : s0_pready) begin
            rd  = (p == 1) ? s1_prdata : s0_prdata;
            er  = (p == 1) ? s1_pslverr : s0_pslverr;
            lat = cnt + 1;
            break;
         end
         if (cnt > 300) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_bound port%0d: no pready after %0d cycles, required within 300", p, cnt);
            break;
         end
      end
      @(posedge pclk);
      #1;
      psel[p] = 1'b0; penable[p] = 1'b0;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
   endtask

   logic [31:0] rd0, rd1;
   logic        er0, er1;
   int          lat0, lat1, pc0;
   longint      t0, t1;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      psel = '0; penable = '0; pwrite = '0;
      for (int i = 0; i < 2; i++) begin
         paddr[i] = '0; pwdata[i] = '0; pwstrb[i] = '0;
         dn_wait[i] = 0; dn_data[i] = '0; dn_err[i] = 1'b0;
      end
      #3;
      check("reset_m_paddr", m_paddr, 0);
      check("reset_m_pwdata", m_pwdata, 0);
      check("reset_m_penable", m_penable, 0);
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;

      // Port 0 read, five downstream wait cycles.
      dn_wait[0] = 5; dn_data[0] = 32'hDEAD_BEEF;
      xfer(0, 32'h4000_0010, 1'b0, 32'h0, 4'h0, rd0, er0, lat0);
      check("p0_read_data", rd0, 32'hDEAD_BEEF);
      check("p0_read_err", er0, 0);
      check("p0_read_lat", lat0, 9);

      // Ties straight after reset: port 0 first, then again after port 1 was served.
      do_reset();
      dn_wait[0] = 1; dn_wait[1] = 1; dn_data[0] = 32'hA000_0000; dn_data[1] = 32'hB000_0001;
      for (int r = 0; r < 2; r++) begin
         dn_err[1] = (r == 1);
         fork
            begin xfer(0, 32'h100, 1'b0, 32'h0, 4'h0, rd0, er0, lat0); t0 = $time; end
            begin xfer(1, 32'h200, 1'b0, 32'h0, 4'h0, rd1, er1, lat1); t1 = $time; end
         join
         check("tie_order", t0 < t1, 1);
         check("tie_lat0", lat0, 5);
         check("tie_lat1", lat1, 10);
         check("tie_data0", rd0, 32'hA000_0000);
         check("tie_data1", rd1, 32'hB000_0001);
         check("tie_err1", er1, r == 1);
      end
      dn_err[1] = 1'b0;

      // Port 1 write, zero wait: minimum latency and forwarded fields.
      dn_wait[1] = 0; dn_data[1] = 32'h0;
      xfer(1, 32'h0000_0010, 1'b1, 32'h1234_5678, 4'h3, rd1, er1, lat1);
      check("wr_lat", lat1, 4);
      check("wr_m_paddr", snap_addr, 32'h10);
      check("wr_m_pwdata", snap_wdata, 32'h1234_5678);
      check("wr_m_pwstrb", snap_strb, 4'h3);
      check("wr_m_pwrite", snap_write, 1);

      // Timeout with a competing port-1 request that must wait for the drain.
      pc0 = pulse_cnt;
      dn_wait[0] = 12; dn_data[0] = 32'h7777_7777;
      dn_wait[1] = 1;  dn_data[1] = 32'hCAFE_0001;
      fork
         begin xfer(0, 32'h300, 1'b0, 32'h0, 4'h0, rd0, er0, lat0); t0 = $time; end
         begin
            repeat (3) @(posedge pclk);
            #1 xfer(1, 32'h400, 1'b0, 32'h0, 4'h0, rd1, er1, lat1);
            t1 = $time;
         end
      join
      check("to_err", er0, 1);
      check("to_data", rd0, 0);
      check("to_lat", lat0, 11);
      check("to_pulses", pulse_cnt - pc0, 1);
      check("to_p1_data", rd1, 32'hCAFE_0001);
      check("to_p1_lat", lat1, 17);

      // Ready on the exact expiry cycle is a normal completion.
      pc0 = pulse_cnt;
      dn_wait[0] = 7; dn_data[0] = 32'h5A5A_A5A5;
      xfer(0, 32'h500, 1'b0, 32'h0, 4'h0, rd0, er0, lat0);
      check("exp_data", rd0, 32'h5A5A_A5A5);
      check("exp_err", er0, 0);
      check("exp_lat", lat0, 11);
      check("exp_pulses", pulse_cnt - pc0, 0);

      // Asynchronous reset in the middle of ACCESS, then a clean transfer.
      dn_wait[0] = 20;
      paddr[0] = 32'h600; pwrite[0] = 1'b1; pwdata[0] = 32'h1111_2222; pwstrb[0] = 4'hF;
      psel[0] = 1'b1; penable[0] = 1'b0;
      @(posedge pclk);
      #1 penable[0] = 1'b1;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("pre_rst_m_psel", m_psel, 1);
      #2 presetn = 1'b0;
      #1;
      check("arst_m_psel", m_psel, 0);
      check("arst_m_penable", m_penable, 0);
      check("arst_m_paddr", m_paddr, 0);
      check("arst_m_pwrite", m_pwrite, 0);
      check("arst_m_pwdata", m_pwdata, 0);
      check("arst_m_pwstrb", m_pwstrb, 0);
      check("arst_s0_pready", s0_pready, 0);
      psel[0] = 1'b0; penable[0] = 1'b0;
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      dn_wait[0] = 2; dn_data[0] = 32'h1357_9BDF;
      xfer(0, 32'h700, 1'b0, 32'h0, 4'h0, rd0, er0, lat0);
      check("post_rst_data", rd0, 32'h1357_9BDF);
      check("post_rst_lat", lat0, 6);

      repeat (3) @(posedge pclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
